// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

    // Register map
    localparam int unsigned ADDR_TOP      = 0;
    localparam int unsigned ADDR_PRESCALE = 1;
    localparam int unsigned ADDR_CTRL     = 2;
    localparam int unsigned ADDR_DUTY0    = 3;

    // CTRL bit positions; channel enables occupy CTRL_CHEN_LSB upward
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_BIT = 1;
    localparam int unsigned CTRL_CHEN_LSB = 2;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared timebase: prescaler, period counter with up/down direction and
// the boundary strobe marking the step in which the counter returns to 0.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic [WIDTH-1:0]      i_top,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  pwm_mode_e             i_mode,
    output logic [WIDTH-1:0]      o_cnt,
    output logic                  o_boundary
);

    logic [PRESCALE_W-1:0] r_pscnt;
    logic [WIDTH-1:0]      r_cnt;
    logic                  r_down;
    logic [WIDTH-1:0]      w_cnt_nxt;
    logic                  w_down_nxt;
    logic                  w_step;

    // Next counter value and direction for the next step
    always_comb begin
        w_step     = i_en && (r_pscnt == i_prescale);
        w_cnt_nxt  = r_cnt;
        w_down_nxt = r_down;
        if (i_mode == MODE_EDGE) begin
            w_down_nxt = 1'b0;
            w_cnt_nxt  = (r_cnt == i_top) ? '0 : r_cnt + 1'b1;
        end else if (i_top == '0) begin
            w_down_nxt = 1'b0;
            w_cnt_nxt  = '0;
        end else if (!r_down) begin
            // Direction flips as the counter arrives at TOP, so TOP is visited once
            w_cnt_nxt  = r_cnt + 1'b1;
            w_down_nxt = (w_cnt_nxt == i_top);
        end else begin
            w_cnt_nxt  = r_cnt - 1'b1;
            w_down_nxt = (w_cnt_nxt != '0);
        end
        o_boundary = w_step && (w_cnt_nxt == '0);
    end

    // Prescaler and counter state; held at zero/up while disabled
    always_ff @(posedge clk) begin
        if (!reset || !i_en) begin
            r_pscnt <= '0;
            r_cnt   <= '0;
            r_down  <= 1'b0;
        end else if (w_step) begin
            r_pscnt <= '0;
            r_cnt   <= w_cnt_nxt;
            r_down  <= w_down_nxt;
        end else begin
            r_pscnt <= r_pscnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: register file with shadow/active copies,
// shared timebase and one duty comparator per channel.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned PRESCALE_W = 8,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_tick
);

    // Shadow copies (written by the bus)
    logic [WIDTH-1:0]      r_sh_top;
    logic [PRESCALE_W-1:0] r_sh_pre;
    logic [CHANNELS+1:0]   r_sh_ctrl;
    logic [WIDTH-1:0]      r_sh_duty [CHANNELS];

    // Active copies (used by timebase and comparators)
    logic [WIDTH-1:0]      r_top;
    logic [PRESCALE_W-1:0] r_pre;
    pwm_mode_e             r_mode;
    logic [CHANNELS-1:0]   r_chen;
    logic [WIDTH-1:0]      r_duty [CHANNELS];

    logic [CHANNELS-1:0]   r_pwm;
    logic                  r_bnd_q;
    logic                  r_tick;

    logic                  w_en;
    logic                  w_load;
    logic                  w_boundary;
    logic [WIDTH-1:0]      w_cnt;
    logic [CHANNELS-1:0]   w_cmp;

    assign w_en   = r_sh_ctrl[CTRL_EN_BIT];
    assign w_load = !w_en || w_boundary;

    // Bus writes into the shadow registers; unmapped addresses fall through
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sh_top  <= '0;
            r_sh_pre  <= '0;
            r_sh_ctrl <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) r_sh_duty[i] <= '0;
        end else if (wr_en) begin
            if (wr_addr == ADDR_W'(ADDR_TOP))      r_sh_top  <= wr_data;
            if (wr_addr == ADDR_W'(ADDR_PRESCALE)) r_sh_pre  <= wr_data[PRESCALE_W-1:0];
            if (wr_addr == ADDR_W'(ADDR_CTRL))     r_sh_ctrl <= wr_data[CHANNELS+1:0];
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (wr_addr == ADDR_W'(ADDR_DUTY0 + i)) r_sh_duty[i] <= wr_data;
            end
        end
    end

    // Active copies follow shadow continuously when disabled, else only at a boundary
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_top  <= '0;
            r_pre  <= '0;
            r_mode <= MODE_EDGE;
            r_chen <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) r_duty[i] <= '0;
        end else if (w_load) begin
            r_top  <= r_sh_top;
            r_pre  <= r_sh_pre;
            r_mode <= pwm_mode_e'(r_sh_ctrl[CTRL_MODE_BIT]);
            r_chen <= r_sh_ctrl[CTRL_CHEN_LSB +: CHANNELS];
            for (int unsigned i = 0; i < CHANNELS; i++) r_duty[i] <= r_sh_duty[i];
        end
    end

    pwm_timebase #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_en),
        .i_top      (r_top),
        .i_prescale (r_pre),
        .i_mode     (r_mode),
        .o_cnt      (w_cnt),
        .o_boundary (w_boundary)
    );

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign w_cmp[gi] = (w_cnt < r_duty[gi]);
    end

    // Registered outputs; the boundary is delayed twice so the tick lines up
    // with the pwm sample taken from cnt = 0
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pwm   <= '0;
            r_bnd_q <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_pwm   <= {CHANNELS{w_en}} & r_chen & w_cmp;
            r_bnd_q <= w_boundary;
            r_tick  <= r_bnd_q && w_en;
        end
    end

    assign pwm         = r_pwm;
    assign period_tick = r_tick;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (4 channels, 16-bit counter).
module tb_pwm_multi;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned PW = 8;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [CH-1:0] pwm;
    logic          period_tick;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_multi #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .PRESCALE_W (PW),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm         (pwm),
        .period_tick (period_tick)
    );

    // Single register write; returns on the negedge just after the write edge
    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (pwm !== 4'b0000) begin
                n_err++; $display("FAIL reset_pwm k=%0d got=%b want=%b", k, pwm, 4'b0000);
            end
            n_cmp++;
            if (period_tick !== 1'b0) begin
                n_err++; $display("FAIL reset_tick k=%0d got=%b want=%b", k, period_tick, 1'b0);
            end
        end
    endtask

    // TOP=3, DUTY0=2, DUTY1=3, DUTY2=4 (ch2 disabled); includes an unmapped write
    task automatic test_edge;
        logic [CH-1:0] exp_pwm;
        logic          exp_tick;
        do_reset();
        wr(4'd0, 16'd3); wr(4'd3, 16'd2); wr(4'd4, 16'd3); wr(4'd5, 16'd4);
        wr(4'd2, 16'd12); wr(4'd2, 16'd13);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            case (k % 4)
                0, 1:    exp_pwm = 4'b0011;
                2:       exp_pwm = 4'b0010;
                default: exp_pwm = 4'b0000;
            endcase
            exp_tick = (k != 0) && (k % 4 == 0);
            n_cmp++;
            if (pwm !== exp_pwm) begin
                n_err++; $display("FAIL edge_pwm k=%0d got=%b want=%b", k, pwm, exp_pwm);
            end
            n_cmp++;
            if (period_tick !== exp_tick) begin
                n_err++; $display("FAIL edge_tick k=%0d got=%b want=%b", k, period_tick, exp_tick);
            end
            if (k == 5) begin
                wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'd0;
            end else if (k == 6) begin
                wr_en = 1'b0; wr_addr = '0;
            end
        end
    endtask

    task automatic test_center;
        logic [CH-1:0] exp_pwm;
        logic          exp_tick;
        do_reset();
        wr(4'd0, 16'd3); wr(4'd3, 16'd2); wr(4'd2, 16'd6); wr(4'd2, 16'd7);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            case (k % 6)
                0, 1, 5: exp_pwm = 4'b0001;
                default: exp_pwm = 4'b0000;
            endcase
            exp_tick = (k != 0) && (k % 6 == 0);
            n_cmp++;
            if (pwm !== exp_pwm) begin
                n_err++; $display("FAIL center_pwm k=%0d got=%b want=%b", k, pwm, exp_pwm);
            end
            n_cmp++;
            if (period_tick !== exp_tick) begin
                n_err++; $display("FAIL center_tick k=%0d got=%b want=%b", k, period_tick, exp_tick);
            end
        end
    endtask

    task automatic test_prescale;
        logic [CH-1:0] exp_pwm;
        logic          exp_tick;
        do_reset();
        wr(4'd0, 16'd1); wr(4'd1, 16'd2); wr(4'd3, 16'd1); wr(4'd2, 16'd4); wr(4'd2, 16'd5);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            exp_pwm  = (k % 6 < 3) ? 4'b0001 : 4'b0000;
            exp_tick = (k != 0) && (k % 6 == 0);
            n_cmp++;
            if (pwm !== exp_pwm) begin
                n_err++; $display("FAIL presc_pwm k=%0d got=%b want=%b", k, pwm, exp_pwm);
            end
            n_cmp++;
            if (period_tick !== exp_tick) begin
                n_err++; $display("FAIL presc_tick k=%0d got=%b want=%b", k, period_tick, exp_tick);
            end
        end
    endtask

    // DUTY0 1 -> 6 written while cnt = 3; new duty only from the next period
    task automatic test_shadow;
        logic [CH-1:0] exp_pwm;
        logic          exp_tick;
        do_reset();
        wr(4'd0, 16'd7); wr(4'd3, 16'd1); wr(4'd2, 16'd4); wr(4'd2, 16'd5);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k < 8) exp_pwm = (k == 0) ? 4'b0001 : 4'b0000;
            else       exp_pwm = (k % 8 < 6) ? 4'b0001 : 4'b0000;
            exp_tick = (k == 8) || (k == 16);
            n_cmp++;
            if (pwm !== exp_pwm) begin
                n_err++; $display("FAIL shadow_pwm k=%0d got=%b want=%b", k, pwm, exp_pwm);
            end
            n_cmp++;
            if (period_tick !== exp_tick) begin
                n_err++; $display("FAIL shadow_tick k=%0d got=%b want=%b", k, period_tick, exp_tick);
            end
            if (k == 2) begin
                wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'd6;
            end else if (k == 3) begin
                wr_en = 1'b0; wr_addr = '0; wr_data = '0;
            end
        end
    endtask

    task automatic test_duty_limits;
        logic          exp_tick;
        do_reset();
        wr(4'd0, 16'd7); wr(4'd3, 16'd0); wr(4'd2, 16'd4); wr(4'd2, 16'd5);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_tick = (k == 8);
            n_cmp++;
            if (pwm !== 4'b0000) begin
                n_err++; $display("FAIL duty0_pwm k=%0d got=%b want=%b", k, pwm, 4'b0000);
            end
            n_cmp++;
            if (period_tick !== exp_tick) begin
                n_err++; $display("FAIL duty0_tick k=%0d got=%b want=%b", k, period_tick, exp_tick);
            end
        end
        do_reset();
        wr(4'd0, 16'd7); wr(4'd3, 16'd8); wr(4'd2, 16'd4); wr(4'd2, 16'd5);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n_cmp++;
            if (pwm !== 4'b0001) begin
                n_err++; $display("FAIL dutyfull_pwm k=%0d got=%b want=%b", k, pwm, 4'b0001);
            end
        end
    endtask

    // TOP left at its reset value 0: every step is a boundary
    task automatic test_top_zero;
        logic exp_tick;
        do_reset();
        wr(4'd3, 16'd1); wr(4'd2, 16'd4); wr(4'd2, 16'd5);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_tick = (k >= 1);
            n_cmp++;
            if (pwm !== 4'b0001) begin
                n_err++; $display("FAIL top0_pwm k=%0d got=%b want=%b", k, pwm, 4'b0001);
            end
            n_cmp++;
            if (period_tick !== exp_tick) begin
                n_err++; $display("FAIL top0_tick k=%0d got=%b want=%b", k, period_tick, exp_tick);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic exp_tick;
        do_reset();
        wr(4'd0, 16'd3); wr(4'd3, 16'd2); wr(4'd2, 16'd4); wr(4'd2, 16'd5);
        // k=3 sample: next edge would give pwm=1 and period_tick=1
        for (int k = 0; k < 4; k++) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pwm !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_pwm got=%b want=%b", pwm, 4'b0000);
        end
        n_cmp++;
        if (period_tick !== 1'b0) begin
            n_err++; $display("FAIL rstmid_tick got=%b want=%b", period_tick, 1'b0);
        end
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({pwm, period_tick} !== 5'b00000) begin
                n_err++; $display("FAIL rstmid_idle k=%0d got=%b want=%b", k, {pwm, period_tick}, 5'b00000);
            end
        end
        // Only EN rewritten: cleared TOP=0 gives ticks, cleared DUTY/chen give pwm=0
        wr(4'd2, 16'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_tick = (k >= 1);
            n_cmp++;
            if (pwm !== 4'b0000) begin
                n_err++; $display("FAIL rstmid_en_pwm k=%0d got=%b want=%b", k, pwm, 4'b0000);
            end
            n_cmp++;
            if (period_tick !== exp_tick) begin
                n_err++; $display("FAIL rstmid_en_tick k=%0d got=%b want=%b", k, period_tick, exp_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_prescale();
        test_shadow();
        test_duty_limits();
        test_top_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator, successor to the single-channel PWM block. One shared timebase (prescaler plus period counter) drives CHANNELS independent duty comparators, in edge-aligned or center-aligned mode. Writes go to shadow registers, and all shadows load together at the period boundary, so outputs never glitch mid-period. It sits between the register/config logic and the output pins (LED/VGA-side drivers).

## Interface
- CHANNELS, 4, number of PWM outputs (1..13)
- WIDTH, 16, period/duty counter width; must be ≥ CHANNELS+2
- PRESCALE_W, 8, prescaler width
- ADDR_W, 4, register address width; 2^ADDR_W ≥ CHANNELS+3
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- wr_en  input  1  register write strobe, one write per cycle
- wr_addr  input  ADDR_W  register address: 0 = TOP, 1 = PRESCALE, 2 = CTRL, 3+i = DUTY[i]
- wr_data  input  WIDTH  write data; PRESCALE uses the low PRESCALE_W bits
- pwm  output  CHANNELS  PWM outputs, registered
- period_tick  output  1  one-cycle pulse at each period boundary

## Operation
- CTRL bits:
  - [0] EN, global enable.
  - [1] MODE: 0 = edge-aligned, 1 = center-aligned.
  - [CHANNELS+1:2] per-channel enables.
- EN takes effect immediately from the shadow. MODE, channel enables, TOP, PRESCALE and DUTY are double-buffered.
- Shadow/active register handling:
  - Writes always land in shadow.
  - Active copies load from shadow on a boundary step.
  - While EN = 0, active copies load from shadow every cycle.
- Writes to unmapped addresses are ignored. Repeated writes before a boundary: last wins.
- A write in the same cycle as a boundary load lands in shadow only. The load uses the pre-write shadow value, and the new value applies at the next boundary.
- Prescaler: counts 0..PRESCALE and issues a step when it equals PRESCALE, then returns to 0. PRESCALE = 0 steps every cycle.
- Edge mode: on each step, cnt = (cnt == TOP) ? 0 : cnt+1. Period = (TOP+1)·(PRESCALE+1) clocks.
- Center mode:
  - On each step, cnt moves up to TOP, then down to 0; direction flips on reaching TOP or 0.
  - Period = 2·TOP steps (sequence 0,1,…,TOP,…,1).
  - TOP = 0 holds cnt at 0.
- Boundary: the step in which cnt becomes 0, including the TOP = 0 case, where every step is a boundary. period_tick asserts in the cycle after that step, aligned with the first pwm sample of the new period.
- Channel output: pwm[i] = EN & chen[i] & (cnt < DUTY[i]), registered.
  - DUTY = 0 gives constant low.
  - DUTY > TOP gives constant high.
- Comparison uses active TOP/DUTY. All arithmetic is unsigned WIDTH-bit, and cnt never exceeds TOP.
- EN = 0:
  - Prescaler and cnt held at 0, direction up.
  - pwm = 0, period_tick = 0.
- EN 0→1: counting starts at cnt = 0, and the first boundary is the next wrap (no tick on enable).
- TOP reduced below the current cnt: not possible, because TOP only changes at a boundary, where cnt = 0.

## Timing
- Reset (reset low at a clk edge) clears all shadow and active registers, the prescaler, cnt and direction.
- Outputs after reset: pwm = 0, period_tick = 0.
- reset asserted mid-period forces pwm low on the next edge.
- Write with EN = 0: active copy updated 1 cycle after wr_en.
- Write with EN = 1: takes effect at the next boundary.
- pwm and period_tick lag the cnt update by 1 clock.
- Writing CTRL.EN = 1: cnt starts counting on the edge after the write. The first pwm sample (cnt = 0) appears 1 cycle after that.

## Structure
- Package pwm_pkg holds:
  - register address constants (ADDR_TOP, ADDR_PRESCALE, ADDR_CTRL, ADDR_DUTY0);
  - CTRL bit positions;
  - mode enum {MODE_EDGE, MODE_CENTER}.
- Sub-module pwm_timebase: prescaler, cnt, up/down direction, boundary strobe. Outputs are cnt and boundary.
- Top level holds the register file, shadow/active copies and a generate loop of per-channel comparators.

## Test plan
- Edge mode: TOP = 3, PRESCALE = 0, DUTY0 = 2, CTRL = EN|ch0 → pwm[0] repeats 1,1,0,0; period_tick every 4 clocks.
- Center mode: TOP = 3, DUTY0 = 2 → cnt 0,1,2,3,2,1; pwm[0] pattern 1,1,0,0,0,1 per 6 clocks.
- Prescale: PRESCALE = 2, TOP = 1, DUTY0 = 1 → pwm[0] high 3 clocks, low 3 clocks; period 6 clocks.
- Shadow: running at DUTY0 = 1 with TOP = 7, write DUTY0 = 6 at cnt = 3 → current period keeps 1 high count; the next period after period_tick has 6 high clocks.
- Boundary cases:
  - DUTY0 = 0 gives constant 0.
  - DUTY0 = 8 with TOP = 7 gives constant 1.
  - TOP = 0 gives period_tick every step.
  - A write to address 15 is ignored.
- Reset: assert reset mid-period → next cycle pwm = 0, period_tick = 0, all registers 0; EN remains 0 until rewritten.
